// File: rtl/lpe_result_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lpe_result_sequencer
//  Purpose  : Column-level result scheduler for a column of PE_NUMBER_J linear
//             processing elements. Grants one shared AXI-Stream result port to
//             the PEs in strict position order (0..PE_NUMBER_J-1), one result
//             per PE per batch. Each result is tagged with its source index
//             plus a user flag, and the final result of a batch carries tlast.
//             A watchdog parks the sequencer in an error state when the
//             granted PE starves the output for TIMEOUT cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : clock
//    rstn           : synchronous active-low reset
//    enable         : permits starting a new batch (sampled at batch edges)
//    clear_err      : leaves the error state
//    s_axis_tdata   : per-PE results, PE i in slice i
//    s_axis_tvalid  : per-PE valid
//    s_axis_tready  : per-PE ready, one-hot or zero
//    m_axis_tdata   : result word
//    m_axis_tvalid  : result valid
//    m_axis_tready  : downstream ready
//    m_axis_tlast   : last result of the batch
//    m_axis_tuser   : RSLT_USER_MASK | source index
//    m_axis_tdest   : constant OUTPUT_DEST
//    busy           : batch in progress (or parked in error)
//    err_timeout    : sticky watchdog error
// ============================================================================
module lpe_result_sequencer #(
  parameter int                    PE_NUMBER_J    = 4,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    USER_WIDTH     = 8,
  parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = {1'b1, {(USER_WIDTH-1){1'b0}}},
  parameter int                    DEST_WIDTH     = 8,
  parameter logic [DEST_WIDTH-1:0] OUTPUT_DEST    = DEST_WIDTH'(1),
  parameter int                    TIMEOUT        = 255
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              enable,
  input  logic                              clear_err,
  input  logic [PE_NUMBER_J*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PE_NUMBER_J-1:0]            s_axis_tvalid,
  output logic [PE_NUMBER_J-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  output logic                              busy,
  output logic                              err_timeout
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_idx_w = $clog2(PE_NUMBER_J);
  // The timer never needs to hold more than TIMEOUT-1.
  localparam int c_tmr_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PE_NUMBER_J - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [c_tmr_w-1:0]      timer_q, timer_d;
  logic                    err_q, err_d;

  // Single-stage output register
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [USER_WIDTH-1:0]   out_user_q, out_user_d;
  logic                    out_last_q, out_last_d;

  // --------------------------------------------------------------------------
  // Per-PE data slices
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   w_pe_data [PE_NUMBER_J];

  for (genvar gi = 0; gi < PE_NUMBER_J; gi++) begin : g_slice
    assign w_pe_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  logic                    w_free;     // output register can accept a word
  logic                    w_gvalid;   // granted PE presents a result
  logic                    w_hs;       // granted PE handshake this cycle
  logic                    w_age;      // cycle counts against the watchdog
  logic                    w_expire;   // watchdog fires this cycle
  logic [PE_NUMBER_J-1:0]  w_tready;

  assign w_free   = !out_valid_q || m_axis_tready;
  assign w_gvalid = s_axis_tvalid[idx_q];
  assign w_hs     = (state_q == ST_GRANT) && w_free && w_gvalid;
  // Only a starving PE ages the timer; a stalled downstream does not.
  assign w_age    = (state_q == ST_GRANT) && w_free && !w_gvalid;
  // w_age excludes a handshake, so a result arriving on the expiry cycle wins.
  assign w_expire = w_age && (TIMEOUT != 0) && (timer_q == c_tmr_last);

  always_comb begin
    w_tready = '0;
    if (state_q == ST_GRANT) begin
      w_tready[idx_q] = w_free;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    err_d       = err_q;

    // The pending word drains in every state, including ERR.
    out_valid_d = out_valid_q && !m_axis_tready;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;

    if (w_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = w_pe_data[idx_q];
      out_user_d  = RSLT_USER_MASK | {{(USER_WIDTH-c_idx_w){1'b0}}, idx_q};
      out_last_d  = (idx_q == c_last_idx);
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_GRANT;
          idx_d   = '0;
          timer_d = '0;
        end
      end

      ST_GRANT: begin
        if (w_hs) begin
          timer_d = '0;
          if (idx_q == c_last_idx) begin
            idx_d = '0;
            // Batch boundary: the only point where enable is looked at.
            if (!enable) begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (w_expire) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (w_age && (timer_q != '1)) begin
          // Saturating so a disabled watchdog (TIMEOUT=0) cannot wrap.
          timer_d = timer_q + 1'b1;
        end
      end

      ST_ERR: begin
        if (clear_err) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          timer_d = '0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_tready = w_tready;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tdest  = OUTPUT_DEST;
  assign busy          = (state_q == ST_GRANT) || (state_q == ST_ERR);
  assign err_timeout   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lpe_result_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lpe_result_sequencer
//  Purpose  : Self-checking bench for lpe_result_sequencer. A behavioural
//             model tracks the expected output word, grant position, starving
//             cycle count and error flag; a negedge monitor compares the DUT
//             with it every cycle and also checks stream ordering invariants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lpe_result_sequencer;

  localparam int             N    = 4;
  localparam int             DW   = 16;
  localparam int             UW   = 8;
  localparam int             DSW  = 8;
  localparam int             TMO  = 8;
  localparam logic [UW-1:0]  MASK = 8'h80;
  localparam logic [DSW-1:0] DEST = 8'd1;

  logic            clk = 1'b0;
  logic            rstn, enable, clear_err;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tready, m_tlast;
  logic [UW-1:0]   m_tuser;
  logic [DSW-1:0]  m_tdest;
  logic            busy, err;

  always #5 clk = ~clk;

  lpe_result_sequencer #(
    .PE_NUMBER_J(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .RSLT_USER_MASK(MASK),
    .DEST_WIDTH(DSW), .OUTPUT_DEST(DEST), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clear_err(clear_err),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest),
    .busy(busy), .err_timeout(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: phase 0=idle 1=granting 2=error
  // --------------------------------------------------------------------------
  int            ph = 0, g_pos = 0, starve = 0;
  bit            m_err = 0, e_valid = 0, e_last = 0, model_ok = 0, rst_edge = 0;
  logic [DW-1:0] e_data = '0;
  logic [UW-1:0] e_user = '0;
  bit            m_fr, m_take;
  int            cyc = 0;
  int            out_pos = 0;
  bit            restart = 0;

  always @(posedge clk) begin
    cyc++;
    rst_edge = !rstn;
    if (!rstn) begin
      ph = 0; g_pos = 0; starve = 0; m_err = 0;
      e_valid = 0; e_data = '0; e_user = '0; e_last = 0;
      out_pos = 0; restart = 0;
      model_ok = 1;
    end else if (model_ok) begin
      m_fr   = !e_valid || m_tready;
      m_take = (ph == 1) && m_fr && s_tvalid[g_pos];
      if (e_valid && m_tready) e_valid = 0;
      if (m_take) begin
        e_valid = 1;
        e_data  = s_tdata[g_pos*DW +: DW];
        e_user  = MASK | UW'(g_pos);
        e_last  = (g_pos == N-1);
      end
      case (ph)
        0: if (enable) begin ph = 1; g_pos = 0; starve = 0; end
        1: begin
          if (m_take) begin
            starve = 0;
            if (g_pos == N-1) begin
              g_pos = 0;
              if (!enable) ph = 0;
            end else begin
              g_pos++;
            end
          end else if (m_fr) begin
            starve++;
            if (TMO != 0 && starve >= TMO) begin ph = 2; m_err = 1; end
          end
        end
        default: if (clear_err) begin
          ph = 0; g_pos = 0; starve = 0; m_err = 0;
          if (e_valid) restart = 1; else out_pos = 0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / compare process
  // --------------------------------------------------------------------------
  logic [DW-1:0] cap_data[$];
  logic [UW-1:0] cap_user[$];
  bit            cap_last[$];
  int            cap_cyc[$];
  int            hs0_edge = -1, err_edge = -1;
  bit            err_prev = 0, prev_stall = 0;
  logic [DW-1:0] sv_data;
  logic [UW-1:0] sv_user;
  logic          sv_last;
  logic [N-1:0]  exp_ready;

  always @(negedge clk) begin
    if (model_ok) begin
      exp_ready = '0;
      if (ph == 1 && (!e_valid || m_tready)) exp_ready[g_pos] = 1'b1;
      chk("s_tready", s_tready, exp_ready);
      chk("ready_onehot", $countones(s_tready) <= 1, 1);
      chk("m_tvalid", m_tvalid, e_valid);
      chk("busy", busy, ph != 0);
      chk("err_timeout", err, m_err);
      chk("m_tdest", m_tdest, DEST);
      if (e_valid) begin
        chk("m_tdata", m_tdata, e_data);
        chk("m_tuser", m_tuser, e_user);
        chk("m_tlast", m_tlast, e_last);
      end
      if (prev_stall && !rst_edge) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, sv_data);
        chk("stall_user", m_tuser, sv_user);
        chk("stall_last", m_tlast, sv_last);
      end
      prev_stall = m_tvalid && !m_tready;
      sv_data = m_tdata; sv_user = m_tuser; sv_last = m_tlast;
      if (m_tvalid && m_tready) begin
        chk("seq_index", m_tuser & ~MASK, out_pos);
        chk("seq_tlast", m_tlast, out_pos == N-1);
        out_pos = restart ? 0 : (out_pos + 1) % N;
        restart = 0;
        cap_data.push_back(m_tdata);
        cap_user.push_back(m_tuser);
        cap_last.push_back(m_tlast);
        cap_cyc.push_back(cyc);
      end
      if ((s_tready[0] & s_tvalid[0]) != 0) hs0_edge = cyc + 1;
      if (err && !err_prev) err_edge = cyc;
      err_prev = err;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_user.delete(); cap_last.delete(); cap_cyc.delete();
  endtask

  task automatic chk_reset_values();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic chk_ordered_batch(input string name);
    chk({name, "_count"}, cap_data.size(), 4);
    if (cap_data.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({name, "_data"}, cap_data[i], 16'hA0 + i);
        chk({name, "_user"}, cap_user[i], 8'h80 + i);
        chk({name, "_last"}, cap_last[i], i == 3);
      end
    end
  endtask

  int mode;
  bit done;

  initial begin
    rstn = 0; enable = 0; clear_err = 0; s_tdata = '0; s_tvalid = '0; m_tready = 0;
    tick(); tick();
    chk_reset_values();
    rstn = 1;
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = 16'hA0 + 16'(i);

    // Ordered batch, PE3 presents first
    clear_caps();
    m_tready = 1; enable = 1; s_tvalid = 4'b1000;
    tick();
    enable = 0; s_tvalid = 4'b1111;
    repeat (8) tick();
    chk_ordered_batch("ordered");
    if (cap_cyc.size() >= 4) chk("ordered_rate", cap_cyc[3] - cap_cyc[0], 3);
    chk("ordered_idle", busy, 0);

    // Backpressure 1010
    clear_caps();
    enable = 1;
    tick();
    enable = 0;
    for (int i = 0; i < 16; i++) begin
      m_tready = (i % 2 == 0);
      tick();
    end
    m_tready = 1;
    repeat (3) tick();
    chk_ordered_batch("bp");

    // Back-to-back batches
    clear_caps();
    enable = 1;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (cap_data.size() >= 10) begin enable = 0; done = 1; end
    end
    chk("b2b_reached", done, 1);
    if (cap_data.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("b2b_last", cap_last[i], (i == 3) || (i == 7));
      chk("b2b_nobubble", cap_cyc[7] - cap_cyc[0], 7);
    end
    repeat (10) tick();
    chk("b2b_total", cap_data.size(), 12);
    chk("b2b_idle", busy, 0);

    // Timeout: PE1 never valid
    clear_caps();
    s_tvalid = 4'b1101; enable = 1; err_edge = -1;
    tick();
    enable = 0;
    repeat (20) tick();
    chk("to_err", err, 1);
    chk("to_ready", s_tready, 0);
    chk("to_busy", busy, 1);
    chk("to_delay", err_edge - hs0_edge, 8);
    chk("to_drained", cap_data.size(), 1);
    clear_err = 1;
    tick();
    clear_err = 0;
    chk("clr_busy", busy, 0);
    chk("clr_err", err, 0);
    clear_caps();
    s_tvalid = 4'b1111; enable = 1;
    tick();
    enable = 0;
    repeat (8) tick();
    chk_ordered_batch("after_clr");

    // Race: PE1 valid on the expiry cycle
    clear_caps();
    s_tvalid = 4'b0001; enable = 1;
    tick();
    enable = 0;
    tick();
    repeat (7) tick();
    s_tvalid = 4'b0011;
    tick();
    chk("race_err", err, 0);
    chk("race_valid", m_tvalid, 1);
    chk("race_user", m_tuser, 8'h81);
    s_tvalid = 4'b1111;
    repeat (6) tick();
    chk("race_idle", busy, 0);
    chk("race_err_end", err, 0);

    // Reset mid-batch
    clear_caps();
    enable = 1;
    tick();
    enable = 0;
    repeat (3) tick();
    rstn = 0;
    tick();
    chk_reset_values();
    rstn = 1;
    clear_caps();
    enable = 1;
    tick();
    enable = 0;
    repeat (8) tick();
    chk_ordered_batch("post_rst");

    // Randomized traffic
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 48 == 0) mode = $urandom_range(0, 2);
      rstn      = ($urandom_range(0, 499) != 0);
      enable    = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      m_tready  = ($urandom_range(0, 2) != 0);
      s_tdata   = {$urandom, $urandom};
      case (mode)
        0:       s_tvalid = 4'($urandom | $urandom);
        1:       s_tvalid = 4'($urandom & $urandom & $urandom);
        default: s_tvalid = 4'($urandom);
      endcase
      tick();
    end
    rstn = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lpe_result_sequencer.md
Name: lpe_result_sequencer

Overview:
- Column-level result scheduler for a PE_NUMBER_J-deep column of linear processing elements.
- Grants the shared result output to PEs in strict position order 0..PE_NUMBER_J-1, one result per PE per batch.
- Tags each result with its source index and the result user flag, and marks the batch end with tlast.
- A watchdog flags a PE that never delivers its result; the sequencer then parks in an error state.

Parameters:
- PE_NUMBER_J, 4, number of PEs in the column (>=2).
- DATA_WIDTH, 16, result word width.
- USER_WIDTH, 8, tuser width (>= clog2(PE_NUMBER_J)+1).
- RSLT_USER_MASK, 1<<(USER_WIDTH-1), flag OR-ed into every output tuser.
- OUTPUT_DEST, 1, constant driven on m_axis_tdest.
- DEST_WIDTH, 8, tdest width.
- TIMEOUT, 255, maximum wait cycles for the granted PE; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- enable  in  1  permits starting a new batch.
- clear_err  in  1  leaves the error state.
- s_axis_tdata  in  PE_NUMBER_J*DATA_WIDTH  per-PE results; PE i occupies slice i.
- s_axis_tvalid  in  PE_NUMBER_J  per-PE valid.
- s_axis_tready  out  PE_NUMBER_J  per-PE ready; one-hot or zero.
- m_axis_tdata  out  DATA_WIDTH  result.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last result of the batch.
- m_axis_tuser  out  USER_WIDTH  RSLT_USER_MASK | source index.
- m_axis_tdest  out  DEST_WIDTH  OUTPUT_DEST.
- busy  out  1  batch in progress.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, idx=0, timer=0.
  - m_axis_tvalid=0, tdata=0, tlast=0, tuser=0.
  - s_axis_tready=0, busy=0, err_timeout=0.
  - Reset mid-batch discards the output register contents with no tlast emitted.
- Output register: single stage, "free" = !m_axis_tvalid || m_axis_tready.
  - A downstream handshake and a new load in the same cycle are legal, giving 1 result/cycle throughput.
  - Latency is 1 cycle: an input handshake at edge k makes m_axis_tvalid=1 after edge k.
- IDLE:
  - busy=0 and all s_axis_tready=0.
  - If enable=1, go to GRANT with idx=0 and timer=0.
- GRANT:
  - busy=1; s_axis_tready[idx]=free; all other ready bits=0. A valid on a non-granted PE is ignored and is not an error.
  - On s_axis_tvalid[idx] && tready, load the output register:
    - tdata = slice idx; tuser = RSLT_USER_MASK | idx; tlast = (idx==PE_NUMBER_J-1).
    - Reset timer to 0.
    - If idx==PE_NUMBER_J-1: idx wraps to 0. Stay in GRANT if enable=1 (back-to-back batch, no bubble); otherwise go to IDLE.
    - Else idx = idx+1.
  - enable is sampled only at a batch boundary. Deasserting it mid-batch does not abort the batch.
  - Watchdog: timer increments only when free && !s_axis_tvalid[idx]. Downstream backpressure does not age the timer.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 while incrementing, go to ERR; timer saturates.
- ERR:
  - err_timeout=1 (sticky); all s_axis_tready=0; busy=1.
  - A pending output word still drains normally.
  - clear_err=1 goes to IDLE with idx=0, timer=0, err_timeout=0. Ordering is restarted from PE 0.
  - clear_err outside ERR has no effect.
- Simultaneous events:
  - A granted handshake in the same cycle the timer would expire: the handshake wins and no error is raised.
  - rstn=0 overrides everything, including clear_err and enable.
- Invariants the bench checks every cycle:
  - popcount(s_axis_tready) <= 1.
  - m_axis_* held stable while tvalid && !tready.
  - tuser index sequence is 0,1,..,N-1 per batch.
  - tlast set exactly once per N outputs.
- Illegal state encodings return to IDLE on the next edge.

Test Plan:
- Ordered batch: N=4, enable=1; PEs present 0xA0..0xA3 out of order (PE3 first), m_axis_tready=1 -> output A0,A1,A2,A3; tuser 0x80,0x81,0x82,0x83; tlast only on A3; latency 1 cycle per grant.
- Backpressure: m_axis_tready toggles 1010 while all PEs are valid -> no word lost or duplicated; outputs stable while stalled; timer stays 0.
- Back-to-back batches: enable held high, 8 results -> tlast on the 4th and 8th words, no idle cycle between batches. Drop enable during word 2 -> the batch completes, then IDLE with busy=0.
- Timeout: TIMEOUT=8, PE1 never valid -> err_timeout=1 exactly 8 cycles after the word-0 handshake; all ready=0. Pulse clear_err -> IDLE; the next batch starts at PE0.
- Race: PE1 asserts valid in the cycle the timer would hit TIMEOUT -> the result is accepted and err_timeout stays 0.
- Reset mid-batch: rstn=0 for 1 cycle after word 2 -> all outputs take reset values; the next batch restarts at idx 0.
